// File: rtl/avalon_master_arbiter_if.sv
// avalon_master_arbiter_if: Avalon-MM master bus bundle.
// The master drives address/read/write/writedata; the slave answers.
interface avalon_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic              master_write;
  logic [DATA_W-1:0] master_writedata;
  logic              master_waitrequest;
  logic [DATA_W-1:0] master_readdata;
  logic              master_readdatavalid;

  modport master (
    output master_address,
    output master_read,
    output master_write,
    output master_writedata,
    input  master_waitrequest,
    input  master_readdata,
    input  master_readdatavalid
  );

  modport slave (
    input  master_address,
    input  master_read,
    input  master_write,
    input  master_writedata,
    output master_waitrequest,
    output master_readdata,
    output master_readdatavalid
  );
endinterface

// File: rtl/avalon_master_arbiter.sv
// avalon_master_arbiter: round-robin share of one Avalon-MM master
// between a read client and a write client, one word in flight.
module avalon_master_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [LEN_W-1:0]  rd_len_i,
  output logic              rd_grant_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_data_valid_o,
  output logic              rd_done_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [LEN_W-1:0]  wr_len_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_grant_o,
  output logic              wr_data_ack_o,
  output logic              wr_done_o,
  output logic              busy_o,
  avalon_master_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR
  } state_e;

  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(ADDR_STEP);

  state_e            state_q;
  logic              last_wr_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  idx_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              rd_done_q;
  logic              wr_done_q;

  logic             idle;
  logic             gnt_rd;
  logic             gnt_wr;
  logic [LEN_W-1:0] len_sel;

  // Tie goes to whichever client was not served last.
  assign idle   = (state_q == IDLE) && !rst;
  assign gnt_rd = idle && rd_req_i
               && (!wr_req_i || last_wr_q);
  assign gnt_wr = idle && wr_req_i
               && (!rd_req_i || !last_wr_q);
  assign len_sel = gnt_rd ? rd_len_i : wr_len_i;

  assign rd_grant_o      = gnt_rd;
  assign wr_grant_o      = gnt_wr;
  assign rd_data_o       = rd_data_q;
  assign rd_data_valid_o = rd_valid_q;
  assign rd_done_o       = rd_done_q;
  assign wr_done_o       = wr_done_q;
  assign busy_o          = state_q != IDLE;

  assign bus.master_read  = state_q == RD_ADDR;
  assign bus.master_write = state_q == WR_ADDR;
  assign bus.master_writedata =
    (state_q == WR_ADDR) ? wr_data_i : '0;
  assign bus.master_address =
    base_q + ADDR_W'(idx_q) * STEP;
  assign wr_data_ack_o = (state_q == WR_ADDR)
                      && !bus.master_waitrequest;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_wr_q  <= 1'b1;
      base_q     <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_rd || gnt_wr) begin
            base_q    <= gnt_rd ? rd_addr_i
                                : wr_addr_i;
            rem_q     <= len_sel;
            idx_q     <= '0;
            last_wr_q <= gnt_wr;
            // Empty jobs complete without touching the bus.
            if (len_sel == '0) begin
              rd_done_q <= gnt_rd;
              wr_done_q <= gnt_wr;
            end else begin
              state_q <= gnt_rd ? RD_ADDR
                                : WR_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (!bus.master_waitrequest)
            state_q <= RD_DATA;
        end
        RD_DATA: begin
          if (bus.master_readdatavalid) begin
            rd_data_q  <= bus.master_readdata;
            rd_valid_q <= 1'b1;
            rem_q      <= rem_q - LEN_W'(1);
            idx_q      <= idx_q + LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              rd_done_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              state_q <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (!bus.master_waitrequest) begin
            rem_q <= rem_q - LEN_W'(1);
            idx_q <= idx_q + LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              wr_done_q <= 1'b1;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
